adder_pipe_nbits: RTL and testbench
===================================

// Module: adder_pipe_nbits
// PURPOSE
//  Parametrised, pipelined carry-select adder/subtractor for the ID/EX datapath; next generation of the fixed 32-bit adder.
//  Operand is split into BLK-bit carry-select blocks grouped into STAGES pipeline slices; the carry is registered between slices.
//  Adds subtract mode, signed-overflow/zero flags and a valid/ready handshake with back-pressure.
// PARAMETERS
//  WIDTH   32  operand/result width; WIDTH % (BLK*STAGES) == 0
//  BLK     4   carry-select block width in bits (block 0 is a plain ripple block)
//  STAGES  2   pipeline slices = latency in cycles; 1 <= STAGES <= WIDTH/BLK
// PORTS
//  clk        in   1      clock, all state updates on rising edge
//  rst_n      in   1      synchronous reset, active low
//  in_valid   in   1      a/b/sub/ci valid this cycle
//  in_ready   out  1      block accepts input this cycle
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  sub        in   1      0: s=a+b+ci; 1: s=a+~b+1 (ci ignored)
//  ci         in   1      carry in (add mode only)
//  out_valid  out  1      result fields valid
//  out_ready  in   1      consumer accepts result this cycle
//  s          out  WIDTH  sum/difference, modulo 2^WIDTH
//  co         out  1      carry out of MSB (sub: 1 = no borrow, a>=b unsigned)
//  ovf        out  1      signed overflow: carry into MSB XOR carry out of MSB
//  zero       out  1      s == 0
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): all slice valid bits, s, co, ovf, zero cleared to 0; zero output is 0 in reset, not 1.
//  - Global advance enable adv = !out_valid || out_ready; in_ready = adv (combinational from out_valid/out_ready).
//  - Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
//  - When adv=0 every pipeline register holds (data and valid); no input accepted, outputs stable.
//  - When adv=1 all slices shift by one; slice 0 loads valid=in_valid (bubbles propagate, not collapsed).
//  - Slice k (0..STAGES-1) computes bits [(k+1)*W/STAGES-1 : k*W/STAGES] with the carry registered from slice k-1;
//    slice 0 uses cin = sub ? 1 : ci. Effective b = sub ? ~b : b, inverted at input.
//  - Upper operand bits are skew-delayed alongside; lower result bits are de-skew-delayed so all fields of one
//    operation appear together at out_valid.
//  - Latency: exactly STAGES cycles from in-transfer to out_valid with out_ready held 1; throughput 1 op/cycle.
//  - Within a slice, each BLK block precomputes sums for carry 0 and 1 and selects on incoming carry.
//  - ovf, zero, co computed in final slice from full-width result; registered with s.
//  - Ordering strictly FIFO; no operation dropped or duplicated under any out_ready pattern.
//  - Reset mid-operation: all in-flight ops discarded, out_valid=0 on the cycle after the reset edge.
//  - Simultaneous in-transfer and out-transfer in same cycle is legal and required for full throughput.
// TESTING (WIDTH=32, BLK=4, STAGES=2)
//  - add a=0x0000_FFFF b=0x0000_0001 ci=0 -> after 2 cycles s=0x0001_0000 co=0 ovf=0 zero=0 (carry crosses slice boundary).
//  - add a=0x7FFF_FFFF b=1 ci=0 -> s=0x8000_0000 ovf=1 co=0; add a=0xFFFF_FFFF b=0 ci=1 -> s=0 co=1 zero=1 ovf=0.
//  - sub a=5 b=5 -> s=0 zero=1 co=1; sub a=3 b=5 -> s=0xFFFF_FFFE co=0 ovf=0; sub a=0x8000_0000 b=1 -> s=0x7FFF_FFFF ovf=1.
//  - back-to-back 8 ops, out_ready=1 -> 8 results on 8 consecutive cycles, in order, first at cycle 2.
//  - out_ready=0 for 3 cycles with pipe full -> in_ready=0, s/flags held stable; release -> no loss, no duplication.
//  - rst_n=0 for one edge with 2 ops in flight -> out_valid=0 and s/co/ovf/zero=0 next cycle; no stale result later.
//  - random regression vs. {co,s}=a+(sub?~b:b)+(sub?1:ci) reference, random in_valid/out_ready, also STAGES=1,4 and WIDTH=64.

Source files
------------

// File: rtl/adder_pipe_nbits_if.sv
// rtl/adder_pipe_nbits_if.sv - operand/result handshake bundle for adder_pipe_nbits
interface adder_pipe_nbits_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             ci;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             co;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, sub, ci, out_ready,
        input  in_ready, out_valid, s, co, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, sub, ci, out_ready,
        output in_ready, out_valid, s, co, ovf, zero
    );
endinterface

// File: rtl/adder_pipe_nbits.sv
// rtl/adder_pipe_nbits.sv - pipelined carry-select adder/subtractor with valid/ready handshake
module adder_pipe_nbits #(
    parameter int WIDTH  = 32,
    parameter int BLK    = 4,
    parameter int STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    adder_pipe_nbits_if.slave  bus
);
    localparam int SW   = WIDTH / STAGES;
    localparam int NB   = SW / BLK;
    localparam int LAST = STAGES - 1;

    // Block 0 ripples from the slice carry; later blocks precompute both carries and select.
    function automatic logic [SW:0] slice_add(input logic [SW-1:0] x, input logic [SW-1:0] y,
                                              input logic cin);
        logic [SW-1:0] sum;
        logic          c;
        logic [BLK:0]  r0;
        logic [BLK:0]  r1;
        logic [BLK:0]  r;
        c   = cin;
        sum = '0;
        for (int j = 0; j < NB; j++) begin
            r0 = {1'b0, x[j*BLK +: BLK]} + {1'b0, y[j*BLK +: BLK]};
            r1 = {1'b0, x[j*BLK +: BLK]} + {1'b0, y[j*BLK +: BLK]} + {{BLK{1'b0}}, 1'b1};
            if (j == 0) r = r0 + {{BLK{1'b0}}, c};
            else        r = c ? r1 : r0;
            sum[j*BLK +: BLK] = r[BLK-1:0];
            c = r[BLK];
        end
        return {c, sum};
    endfunction

    logic [WIDTH-1:0]  a_q  [STAGES];
    logic [WIDTH-1:0]  a_d  [STAGES];
    logic [WIDTH-1:0]  b_q  [STAGES];
    logic [WIDTH-1:0]  b_d  [STAGES];
    logic [WIDTH-1:0]  s_q  [STAGES];
    logic [WIDTH-1:0]  s_d  [STAGES];
    logic [STAGES-1:0] c_q, c_d;
    logic [STAGES-1:0] v_q, v_d;
    logic              ovf_q, ovf_d;
    logic              zero_q, zero_d;

    logic [WIDTH-1:0]  st_a [STAGES];
    logic [WIDTH-1:0]  st_b [STAGES];
    logic [WIDTH-1:0]  st_s [STAGES];
    logic [STAGES-1:0] st_c;
    logic [STAGES-1:0] st_v;
    logic [SW:0]       sl;
    logic [WIDTH-1:0]  nxt_s;
    logic              adv;
    logic              msb_cin;
    logic              unused_bits;

    assign adv = !v_q[LAST] || bus.out_ready;

    // Slice 0 takes the ports (b inverted for subtract); slice k takes slice k-1's registers.
    always_comb begin
        st_a[0] = bus.a;
        st_b[0] = bus.sub ? ~bus.b : bus.b;
        st_s[0] = '0;
        st_c[0] = bus.sub | bus.ci;
        st_v[0] = bus.in_valid;
        for (int k = 1; k < STAGES; k++) begin
            st_a[k] = a_q[k-1];
            st_b[k] = b_q[k-1];
            st_s[k] = s_q[k-1];
            st_c[k] = c_q[k-1];
            st_v[k] = v_q[k-1];
        end
    end

    always_comb begin
        sl    = '0;
        nxt_s = '0;
        for (int k = 0; k < STAGES; k++) begin
            sl    = slice_add(st_a[k][k*SW +: SW], st_b[k][k*SW +: SW], st_c[k]);
            nxt_s = st_s[k];
            nxt_s[k*SW +: SW] = sl[SW-1:0];
            a_d[k] = adv ? st_a[k] : a_q[k];
            b_d[k] = adv ? st_b[k] : b_q[k];
            s_d[k] = adv ? nxt_s   : s_q[k];
            c_d[k] = adv ? sl[SW]  : c_q[k];
            v_d[k] = adv ? st_v[k] : v_q[k];
        end
        // Carry into the MSB is recovered from the MSB operand bits and the MSB sum bit.
        msb_cin = st_a[LAST][WIDTH-1] ^ st_b[LAST][WIDTH-1] ^ s_d[LAST][WIDTH-1];
        ovf_d   = adv ? (msb_cin ^ c_d[LAST]) : ovf_q;
        zero_d  = adv ? (s_d[LAST] == '0) : zero_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q    <= '{default: '0};
            b_q    <= '{default: '0};
            s_q    <= '{default: '0};
            c_q    <= '0;
            v_q    <= '0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            s_q    <= s_d;
            c_q    <= c_d;
            v_q    <= v_d;
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    always_comb begin
        unused_bits = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            unused_bits = unused_bits ^ (^a_q[k]) ^ (^b_q[k]) ^ (^s_q[k]);
        end
    end

    assign bus.in_ready  = adv;
    assign bus.out_valid = v_q[LAST];
    assign bus.s         = s_q[LAST];
    assign bus.co        = c_q[LAST];
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_adder_pipe_nbits.sv
// tb/tb_adder_pipe_nbits.sv - self-checking bench for adder_pipe_nbits
module tb_adder_pipe_nbits;
    localparam int W   = 32;
    localparam int BLK = 4;
    localparam int ST  = 2;

    typedef logic [W+2:0] res_t;  // {s, co, ovf, zero}

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    adder_pipe_nbits_if #(.WIDTH(W)) bus();

    adder_pipe_nbits #(.WIDTH(W), .BLK(BLK), .STAGES(ST)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic sub, input logic ci);
        logic [W:0]   full;
        logic [W-1:0] be;
        logic         ovf;
        be   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, be} + (sub ? (W+1)'(1) : (W+1)'(ci));
        ovf  = (a[W-1] == be[W-1]) && (full[W-1] != a[W-1]);
        return {full[W-1:0], full[W], ovf, full[W-1:0] == '0};
    endfunction

    function automatic res_t got();
        return {bus.s, bus.co, bus.ovf, bus.zero};
    endfunction

    task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sub, input logic ci, input logic rdy);
        bus.in_valid  = v;
        bus.a         = a;
        bus.b         = b;
        bus.sub       = sub;
        bus.ci        = ci;
        bus.out_ready = rdy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_valid got=%b want=0", bus.out_valid);
        end
        n_cmp++;
        if (got() !== res_t'(0)) begin
            n_err++; $display("FAIL reset_fields got=%h want=0", got());
        end
        rst_n = 1'b1;
        step();
        n_cmp++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_idle in_ready=%b out_valid=%b want 1/0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] ta [7] = '{32'h0000_FFFF, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'd3, 32'h8000_0000, 32'd10};
        logic [W-1:0] tb [7] = '{32'h0000_0001, 32'd1, 32'd0, 32'd5, 32'd5, 32'd1, 32'd3};
        logic         tsub [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic         tci  [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        res_t         texp [7] = '{{32'h0001_0000, 3'b000}, {32'h8000_0000, 3'b010},
                                   {32'h0000_0000, 3'b101}, {32'h0000_0000, 3'b101},
                                   {32'hFFFF_FFFE, 3'b000}, {32'h7FFF_FFFF, 3'b110},
                                   {32'h0000_0007, 3'b100}};
        int lat;
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, ta[i], tb[i], tsub[i], tci[i], 1'b1);
            #1;
            n_cmp++;
            if (bus.in_ready !== 1'b1) begin
                n_err++; $display("FAIL dir%0d_in_ready got=%b want=1", i, bus.in_ready);
            end
            step();
            drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
            lat = 1;
            while (bus.out_valid !== 1'b1 && lat < 8) begin
                step();
                lat++;
            end
            n_cmp++;
            if (lat != ST) begin
                n_err++; $display("FAIL dir%0d_latency got=%0d want=%0d", i, lat, ST);
            end
            n_cmp++;
            if (got() !== texp[i]) begin
                n_err++; $display("FAIL dir%0d_result got=%h want=%h", i, got(), texp[i]);
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] oa [8];
        logic [W-1:0] ob [8];
        logic         os [8];
        logic         oc [8];
        logic         want_v;
        for (int i = 0; i < 8; i++) begin
            oa[i] = $urandom; ob[i] = $urandom; os[i] = 1'($urandom); oc[i] = 1'($urandom);
        end
        for (int c = 0; c < 8 + ST + 2; c++) begin
            want_v = (c >= ST) && (c - ST < 8);
            n_cmp++;
            if (bus.out_valid !== want_v) begin
                n_err++; $display("FAIL b2b_valid cyc=%0d got=%b want=%b", c, bus.out_valid, want_v);
            end
            if (want_v) begin
                n_cmp++;
                if (got() !== model(oa[c-ST], ob[c-ST], os[c-ST], oc[c-ST])) begin
                    n_err++;
                    $display("FAIL b2b_result cyc=%0d got=%h want=%h", c, got(),
                             model(oa[c-ST], ob[c-ST], os[c-ST], oc[c-ST]));
                end
            end
            if (c < 8) drive(1'b1, oa[c], ob[c], os[c], oc[c], 1'b1);
            else       drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
            #1;
            n_cmp++;
            if (bus.in_ready !== 1'b1) begin
                n_err++; $display("FAIL b2b_in_ready cyc=%0d got=%b want=1", c, bus.in_ready);
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] a0 = $urandom, b0 = $urandom, a1 = $urandom, b1 = $urandom;
        res_t e0 = model(a0, b0, 1'b0, 1'b1);
        res_t e1 = model(a1, b1, 1'b1, 1'b0);
        drive(1'b1, a0, b0, 1'b0, 1'b1, 1'b0);
        step();
        drive(1'b1, a1, b1, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b1, ~a0, ~b0, 1'b0, 1'b0, 1'b0);
        for (int h = 0; h < 4; h++) begin
            #1;
            n_cmp++;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || got() !== e0) begin
                n_err++;
                $display("FAIL bp_hold%0d in_ready=%b out_valid=%b res=%h want 0/1/%h",
                         h, bus.in_ready, bus.out_valid, got(), e0);
            end
            step();
        end
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        step();
        n_cmp++;
        if (bus.out_valid !== 1'b1 || got() !== e1) begin
            n_err++; $display("FAIL bp_second valid=%b res=%h want 1/%h", bus.out_valid, got(), e1);
        end
        step();
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_err++; $display("FAIL bp_drained valid=%b want=0", bus.out_valid);
        end
    endtask

    task automatic test_reset_midflight();
        drive(1'b1, $urandom, $urandom, 1'b0, 1'b0, 1'b1);
        step();
        drive(1'b1, $urandom, $urandom, 1'b1, 1'b0, 1'b1);
        step();
        rst_n = 1'b0;
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        step();
        n_cmp++;
        if (bus.out_valid !== 1'b0 || got() !== res_t'(0)) begin
            n_err++; $display("FAIL rstmid_clear valid=%b res=%h want 0/0", bus.out_valid, got());
        end
        rst_n = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++;
            if (bus.out_valid !== 1'b0) begin
                n_err++; $display("FAIL rstmid_stale%0d valid=%b want=0", i, bus.out_valid);
            end
        end
    endtask

    task automatic test_random();
        res_t         sb [$];
        res_t         prev = '0;
        res_t         want;
        logic         hold = 1'b0;
        logic         v, rdy, sub, ci;
        logic [W-1:0] a, b;
        int           mode;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (hold) begin
                n_cmp++;
                if (bus.out_valid !== 1'b1 || got() !== prev) begin
                    n_err++; $display("FAIL rnd_stable cyc=%0d valid=%b res=%h want 1/%h", cyc, bus.out_valid, got(), prev);
                end
            end
            v    = ($urandom_range(0, 3) != 0);
            rdy  = ($urandom_range(0, 3) != 0);
            mode = $urandom_range(0, 3);
            a    = $urandom;
            b    = (mode == 0) ? W'($urandom) : (mode == 1) ? ~a : (mode == 2) ? a : '0;
            sub  = 1'($urandom);
            ci   = 1'($urandom);
            drive(v, a, b, sub, ci, rdy);
            #1;
            n_cmp++;
            if (bus.in_ready !== (!bus.out_valid || rdy)) begin
                n_err++; $display("FAIL rnd_in_ready cyc=%0d got=%b want=%b", cyc, bus.in_ready, !bus.out_valid || rdy);
            end
            if (bus.out_valid && rdy) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++; $display("FAIL rnd_extra cyc=%0d res=%h want none", cyc, got());
                end else begin
                    want = sb.pop_front();
                    if (got() !== want) begin
                        n_err++; $display("FAIL rnd_result cyc=%0d got=%h want=%h", cyc, got(), want);
                    end
                end
            end
            if (v && bus.in_ready) sb.push_back(model(a, b, sub, ci));
            hold = bus.out_valid && !rdy;
            prev = got();
            step();
        end
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4 * ST + 4; i++) begin
            if (bus.out_valid) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++; $display("FAIL rnd_drain_extra res=%h want none", got());
                end else begin
                    want = sb.pop_front();
                    if (got() !== want) begin
                        n_err++; $display("FAIL rnd_drain got=%h want=%h", got(), want);
                    end
                end
            end
            step();
        end
        n_cmp++;
        if (sb.size() != 0 || bus.out_valid !== 1'b0) begin
            n_err++; $display("FAIL rnd_leftover pending=%0d valid=%b want 0/0", sb.size(), bus.out_valid);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
